cdb_writeback_arbiter: RTL and testbench

//  Transmit side of the writeback interface consumed by reorder_buffer (writeback_valid/idx/value)
//  and of the forwarding interface consumed by issue_queue (fwd_rd/fwd_rd_val).

---
 rtl/cdb_writeback_arbiter_if.sv | 36 +++
 rtl/cdb_writeback_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_writeback_arbiter_if.sv
// Bundle between functional-unit result sources and the CDB writeback arbiter,
// plus the registered CDB beat consumed by the reorder buffer and issue queue.
interface cdb_writeback_arbiter_if #(
    parameter int NUM_SRC   = 3,
    parameter int ROB_IDX_W = 6,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
);
    localparam int SEL_W = $clog2(NUM_SRC);

    // Handshake: source i transfers when src_valid[i] & src_ready[i] at a rising
    // edge; while src_valid[i] is high and src_ready[i] low the source holds its
    // payload stable. The CDB side has no ready: wb_valid is a one-cycle beat.
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_idx;
    logic [NUM_SRC*PREG_W-1:0]    src_phys_rd;
    logic [NUM_SRC*DATA_W-1:0]    src_value;

    logic                         wb_valid;
    logic [ROB_IDX_W-1:0]         wb_rob_idx;
    logic [DATA_W-1:0]            wb_value;
    logic [PREG_W-1:0]            fwd_rd;
    logic [DATA_W-1:0]            fwd_rd_val;
    logic [SEL_W-1:0]             grant_src;

    modport master (
        input  src_valid, src_rob_idx, src_phys_rd, src_value,
        output src_ready, wb_valid, wb_rob_idx, wb_value, fwd_rd, fwd_rd_val, grant_src
    );

    modport slave (
        output src_valid, src_rob_idx, src_phys_rd, src_value,
        input  src_ready, wb_valid, wb_rob_idx, wb_value, fwd_rd, fwd_rd_val, grant_src
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Round-robin writeback arbiter: one-entry buffer per functional unit, one
// registered CDB beat per cycle towards the reorder buffer and issue queue.
module cdb_writeback_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int ROB_IDX_W = 6,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    cdb_writeback_arbiter_if.master bus
);
    localparam int SEL_W = $clog2(NUM_SRC);
    localparam logic [SEL_W:0]   NUM_SRC_E = (SEL_W+1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] LAST_SRC  = SEL_W'(NUM_SRC - 1);

    logic [NUM_SRC-1:0]   hold_valid_q, hold_valid_d;
    logic [ROB_IDX_W-1:0] hold_rob_q [NUM_SRC];
    logic [ROB_IDX_W-1:0] hold_rob_d [NUM_SRC];
    logic [PREG_W-1:0]    hold_prd_q [NUM_SRC];
    logic [PREG_W-1:0]    hold_prd_d [NUM_SRC];
    logic [DATA_W-1:0]    hold_val_q [NUM_SRC];
    logic [DATA_W-1:0]    hold_val_d [NUM_SRC];
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 wb_valid_q, wb_valid_d;
    logic [ROB_IDX_W-1:0] wb_rob_idx_q, wb_rob_idx_d;
    logic [DATA_W-1:0]    wb_value_q, wb_value_d;
    logic [PREG_W-1:0]    fwd_rd_q, fwd_rd_d;
    logic [DATA_W-1:0]    fwd_rd_val_q, fwd_rd_val_d;
    logic [SEL_W-1:0]     grant_src_q, grant_src_d;

    logic [NUM_SRC-1:0]   grant, src_ready, accept;
    logic                 win_found;
    logic [SEL_W-1:0]     win_idx, cand;
    logic [SEL_W:0]       cand_sum;

    // First occupied buffer at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        grant     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            cand_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(off);
            if (cand_sum >= NUM_SRC_E) cand_sum = cand_sum - NUM_SRC_E;
            cand = cand_sum[SEL_W-1:0];
            if (!win_found && hold_valid_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (win_found) grant[win_idx] = 1'b1;
    end

    always_comb begin
        hold_valid_d = hold_valid_q & ~grant;
        hold_rob_d   = hold_rob_q;
        hold_prd_d   = hold_prd_q;
        hold_val_d   = hold_val_q;
        rr_ptr_d     = rr_ptr_q;
        wb_valid_d   = 1'b0;
        wb_rob_idx_d = wb_rob_idx_q;
        wb_value_d   = wb_value_q;
        fwd_rd_d     = '1;
        fwd_rd_val_d = fwd_rd_val_q;
        grant_src_d  = grant_src_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = !hold_valid_q[i] || grant[i];
            accept[i]    = bus.src_valid[i] && src_ready[i] && !flush;
            if (accept[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_rob_d[i]   = bus.src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                hold_prd_d[i]   = bus.src_phys_rd[i*PREG_W +: PREG_W];
                hold_val_d[i]   = bus.src_value[i*DATA_W +: DATA_W];
            end
        end
        if (win_found && !flush) begin
            rr_ptr_d     = (win_idx == LAST_SRC) ? '0 : win_idx + SEL_W'(1);
            wb_valid_d   = 1'b1;
            wb_rob_idx_d = hold_rob_q[win_idx];
            wb_value_d   = hold_val_q[win_idx];
            fwd_rd_d     = hold_prd_q[win_idx];
            fwd_rd_val_d = hold_val_q[win_idx];
            grant_src_d  = win_idx;
        end
        // A flush drops every buffered result, including the one that would win now.
        if (flush) hold_valid_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_rob_q[i] <= '0;
                hold_prd_q[i] <= '0;
                hold_val_q[i] <= '0;
            end
            rr_ptr_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_rob_idx_q <= '0;
            wb_value_q   <= '0;
            fwd_rd_q     <= '1;
            fwd_rd_val_q <= '0;
            grant_src_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_rob_q   <= hold_rob_d;
            hold_prd_q   <= hold_prd_d;
            hold_val_q   <= hold_val_d;
            rr_ptr_q     <= rr_ptr_d;
            wb_valid_q   <= wb_valid_d;
            wb_rob_idx_q <= wb_rob_idx_d;
            wb_value_q   <= wb_value_d;
            fwd_rd_q     <= fwd_rd_d;
            fwd_rd_val_q <= fwd_rd_val_d;
            grant_src_q  <= grant_src_d;
        end
    end

    assign bus.src_ready  = src_ready;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_rob_idx = wb_rob_idx_q;
    assign bus.wb_value   = wb_value_q;
    assign bus.fwd_rd     = fwd_rd_q;
    assign bus.fwd_rd_val = fwd_rd_val_q;
    assign bus.grant_src  = grant_src_q;

    a_one_grant: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
    a_flush_quiet: assert property (@(posedge clk) disable iff (!reset_n) flush |=> !wb_valid_q);
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Randomized bench for cdb_writeback_arbiter: a behavioural model predicts each
// CDB beat into a queue, and a separate monitor pops and compares real beats.
module tb_cdb_writeback_arbiter;
    localparam int N     = 3;
    localparam int RW    = 6;
    localparam int PW    = 6;
    localparam int DW    = 32;
    localparam int SW    = $clog2(N);
    localparam int W     = SW + RW + PW + DW;
    localparam logic [PW-1:0] NO_RD = '1;

    logic clk;
    logic reset_n;
    logic flush;

    cdb_writeback_arbiter_if #(.NUM_SRC(N), .ROB_IDX_W(RW), .PREG_W(PW), .DATA_W(DW)) bus ();

    cdb_writeback_arbiter #(.NUM_SRC(N), .ROB_IDX_W(RW), .PREG_W(PW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    bit mon_en = 1'b0;
    int beat_cnt [N];

    // ---------------- driver state ----------------
    logic [N-1:0]  drv_valid;
    logic          drv_flush;
    logic [RW-1:0] drv_rob [N];
    logic [PW-1:0] drv_prd [N];
    logic [DW-1:0] drv_val [N];

    // ---------------- reference model ----------------
    bit            m_hold [N];
    logic [RW-1:0] m_rob  [N];
    logic [PW-1:0] m_prd  [N];
    logic [DW-1:0] m_val  [N];
    int            m_ptr;
    bit            m_acc  [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hold[i] = 1'b0;
            m_acc[i]  = 1'b0;
        end
        m_ptr = 0;
        exp_q.delete();
    endtask

    task automatic apply();
        flush         = drv_flush;
        bus.src_valid = drv_valid;
        for (int i = 0; i < N; i++) begin
            bus.src_rob_idx[i*RW +: RW] = drv_rob[i];
            bus.src_phys_rd[i*PW +: PW] = drv_prd[i];
            bus.src_value[i*DW +: DW]   = drv_val[i];
        end
    endtask

    // Predict the edge that follows: who wins, who is ready, what gets captured.
    task automatic model_eval();
        int winner;
        logic [N-1:0] exp_ready;
        winner = -1;
        for (int off = 0; off < N; off++) begin
            int s;
            s = (m_ptr + off) % N;
            if (winner < 0 && m_hold[s]) winner = s;
        end
        for (int i = 0; i < N; i++) exp_ready[i] = !m_hold[i] || (winner == i);
        chk("src_ready", 64'(bus.src_ready), 64'(exp_ready));
        for (int i = 0; i < N; i++) m_acc[i] = 1'b0;
        if (drv_flush) begin
            for (int i = 0; i < N; i++) m_hold[i] = 1'b0;
        end else begin
            if (winner >= 0) begin
                exp_q.push_back({SW'(winner), m_rob[winner], m_prd[winner], m_val[winner]});
                m_hold[winner] = 1'b0;
                m_ptr = (winner + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (drv_valid[i] && exp_ready[i]) begin
                    m_hold[i] = 1'b1;
                    m_acc[i]  = 1'b1;
                    m_rob[i]  = drv_rob[i];
                    m_prd[i]  = drv_prd[i];
                    m_val[i]  = drv_val[i];
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        apply();
        #1;
        model_eval();
    endtask

    task automatic new_payload(input int i);
        drv_rob[i] = RW'($urandom_range(0, 63));
        drv_prd[i] = ($urandom_range(0, 3) == 0) ? NO_RD : PW'($urandom_range(0, 62));
        drv_val[i] = $urandom;
    endtask

    task automatic set_src(input int i, input logic [RW-1:0] rob, input logic [PW-1:0] prd,
                           input logic [DW-1:0] val);
        drv_valid[i] = 1'b1;
        drv_rob[i]   = rob;
        drv_prd[i]   = prd;
        drv_val[i]   = val;
    endtask

    task automatic idle(input int n);
        drv_valid = '0;
        drv_flush = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.wb_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=src%0d rob=%0h expected=no beat at %0t",
                                 bus.grant_src, bus.wb_rob_idx, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_src",  64'(bus.grant_src),  64'(e[W-1 -: SW]));
                        chk("wb_rob_idx", 64'(bus.wb_rob_idx), 64'(e[RW+PW+DW-1 -: RW]));
                        chk("fwd_rd",     64'(bus.fwd_rd),     64'(e[PW+DW-1 -: PW]));
                        chk("wb_value",   64'(bus.wb_value),   64'(e[DW-1:0]));
                        chk("fwd_rd_val", 64'(bus.fwd_rd_val), 64'(e[DW-1:0]));
                        beat_cnt[e[W-1 -: SW]]++;
                    end
                end else begin
                    chk("idle_fwd_rd", 64'(bus.fwd_rd), 64'(NO_RD));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c2;
        for (int i = 0; i < N; i++) begin
            beat_cnt[i] = 0;
            new_payload(i);
        end
        model_reset();

        // Reset with every source asserting valid.
        reset_n   = 1'b0;
        drv_flush = 1'b0;
        drv_valid = '1;
        apply();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wb_valid",   64'(bus.wb_valid),   64'(0));
        chk("rst_fwd_rd",     64'(bus.fwd_rd),     64'(NO_RD));
        chk("rst_wb_rob_idx", 64'(bus.wb_rob_idx), 64'(0));
        chk("rst_wb_value",   64'(bus.wb_value),   64'(0));
        chk("rst_fwd_rd_val", 64'(bus.fwd_rd_val), 64'(0));
        chk("rst_grant_src",  64'(bus.grant_src),  64'(0));
        drv_valid = '0;
        apply();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_src_ready", 64'(bus.src_ready), 64'(3'b111));
        mon_en = 1'b1;

        // Contention from rr_ptr=0: grants 0,1,2 on consecutive cycles.
        for (int i = 0; i < N; i++) set_src(i, RW'(10 + i), PW'(20 + i), 32'hC0DE_0000 + i);
        step();
        drv_valid = '0;
        step();
        chk("contend_ready", 64'(bus.src_ready), 64'(3'b001));
        for (int g = 0; g < N; g++) begin
            step();
            chk("contend_valid", 64'(bus.wb_valid), 64'(1));
            chk("contend_order", 64'(bus.grant_src), 64'(g));
        end
        idle(2);

        // Single ALU result: two edges from source to CDB, then a single beat.
        set_src(0, 6'd5, 6'd12, 32'hDEADBEEF);
        step();
        drv_valid = '0;
        step();
        step();
        chk("single_valid", 64'(bus.wb_valid),   64'(1));
        chk("single_rob",   64'(bus.wb_rob_idx), 64'(5));
        chk("single_fwd",   64'(bus.fwd_rd),     64'(12));
        chk("single_val",   64'(bus.fwd_rd_val), 64'(32'hDEADBEEF));
        step();
        chk("single_after_valid", 64'(bus.wb_valid), 64'(0));
        chk("single_after_fwd",   64'(bus.fwd_rd),   64'(NO_RD));
        idle(2);

        // LSU store: beat without a wakeup tag.
        set_src(1, 6'd9, NO_RD, 32'h1234_5678);
        step();
        drv_valid = '0;
        step();
        step();
        chk("nodest_valid", 64'(bus.wb_valid),   64'(1));
        chk("nodest_rob",   64'(bus.wb_rob_idx), 64'(9));
        chk("nodest_fwd",   64'(bus.fwd_rd),     64'(NO_RD));
        idle(2);

        // Source 0 streams, source 2 waits: source 2 must keep getting grants.
        c2 = beat_cnt[2];
        new_payload(0);
        new_payload(2);
        drv_valid = 3'b101;
        for (int k = 0; k < 12; k++) begin
            step();
            if (m_acc[0]) new_payload(0);
            if (m_acc[2]) new_payload(2);
        end
        idle(4);
        checks++;
        if (beat_cnt[2] - c2 < 4) begin
            failures++;
            $display("FAIL fairness_src2 actual=%0d beats required>=4", beat_cnt[2] - c2);
        end

        // Flush with two results held: no stale beats afterwards.
        set_src(0, 6'd33, 6'd7, 32'hAAAA_0001);
        set_src(1, 6'd34, 6'd8, 32'hAAAA_0002);
        step();
        drv_valid = '0;
        drv_flush = 1'b1;
        step();
        drv_flush = 1'b0;
        step();
        chk("flush_wb_valid",  64'(bus.wb_valid),  64'(0));
        chk("flush_src_ready", 64'(bus.src_ready), 64'(3'b111));
        idle(4);

        // Random traffic with occasional flushes; stalled sources hold payload.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!(drv_valid[i] && !m_acc[i] && !drv_flush)) begin
                    drv_valid[i] = ($urandom_range(0, 99) < 60);
                    new_payload(i);
                end
            end
            drv_flush = ($urandom_range(0, 39) == 0);
            step();
        end

        // Asynchronous reset in the middle of traffic.
        drv_flush = 1'b0;
        drv_valid = '1;
        step();
        step();
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_wb_valid",  64'(bus.wb_valid),  64'(0));
        chk("midrst_fwd_rd",    64'(bus.fwd_rd),    64'(NO_RD));
        chk("midrst_src_ready", 64'(bus.src_ready), 64'(3'b111));
        model_reset();
        drv_valid = '0;
        apply();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        mon_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!(drv_valid[i] && !m_acc[i])) begin
                    drv_valid[i] = ($urandom_range(0, 99) < 50);
                    new_payload(i);
                end
            end
            step();
        end

        idle(N + 3);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
